// File: rtl/popcount_stream_acc.sv
// Streaming popcount accumulator: per-beat popcount, frame total, threshold fire bit.
// Optional signed ternary mode (input_b negative mask) under POPCOUNT_TERNARY_EN.
module popcount_stream_acc #(
    parameter  int unsigned WIDTH     = 18,
    parameter  int unsigned MAX_BEATS = 8,
    localparam int unsigned CNT_W     = $clog2(WIDTH + 1),
    localparam int unsigned OUT_W     = $clog2(WIDTH * MAX_BEATS + 1),
`ifdef POPCOUNT_TERNARY_EN
    localparam int unsigned VAL_W     = CNT_W + 1,
    localparam int unsigned RES_W     = OUT_W + 1
`else
    localparam int unsigned VAL_W     = CNT_W,
    localparam int unsigned RES_W     = OUT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
`ifdef POPCOUNT_TERNARY_EN
    input  logic [WIDTH-1:0] input_b,
`endif
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [RES_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_count,
    output logic             out_fire,
    output logic             out_ovf
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {S_ACC, S_CLOSE, S_HOLD} state_e;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;

    logic             v_q;
    logic [VAL_W-1:0] cnt_q;
    logic             last_q;
    logic [RES_W-1:0] thr_q;
    logic [RES_W-1:0] acc_q;
    logic [BEAT_W-1:0] beat_q;
    logic             out_valid_q;
    logic [RES_W-1:0] out_count_q;
    logic             out_fire_q;
    logic             out_ovf_q;

    logic             accept_c;
    logic             first_acc_c;
    logic             closing_acc_c;
    logic             close_c;
    logic [VAL_W-1:0] beat_val_c;
    logic [RES_W-1:0] cnt_ext_c;
    logic [RES_W-1:0] acc_new_c;
    logic             fire_c;

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Beat value, extension to accumulator width and threshold compare per arithmetic mode
`ifdef POPCOUNT_TERNARY_EN
    assign beat_val_c = VAL_W'(popcnt(input_a & ~input_b)) - VAL_W'(popcnt(input_b & ~input_a));
    assign cnt_ext_c  = {{(RES_W - VAL_W){cnt_q[VAL_W-1]}}, cnt_q};
    assign fire_c     = $signed(acc_new_c) >= $signed(thr_q);
`else
    assign beat_val_c = popcnt(input_a);
    assign cnt_ext_c  = RES_W'(cnt_q);
    assign fire_c     = acc_new_c >= thr_q;
`endif

    // Stage 1 sees beats before stage 2 counts them; v_q marks one in flight
    assign accept_c      = in_valid & in_ready_q;
    assign first_acc_c   = (beat_q == '0) & ~v_q;
    assign closing_acc_c = in_last |
                           ((beat_q + BEAT_W'(v_q)) == BEAT_W'(MAX_BEATS - 1));
    assign close_c       = last_q | ((beat_q + BEAT_W'(1)) == BEAT_W'(MAX_BEATS));
    assign acc_new_c     = ((beat_q == '0) ? '0 : acc_q) + cnt_ext_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_ACC;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC:   if (accept_c && closing_acc_c) state_d = S_CLOSE;
            S_CLOSE: state_d = S_HOLD;
            S_HOLD:  if (out_valid_q && out_ready) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    // Output logic: in_ready is registered from the upcoming state
    always_comb begin
        in_ready_d = 1'b0;
        if (state_d == S_ACC) in_ready_d = 1'b1;
    end

    // Datapath: stage-1 popcount, stage-2 accumulate and close
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            thr_q       <= '0;
            acc_q       <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_fire_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            v_q <= accept_c;
            if (accept_c) begin
                cnt_q  <= beat_val_c;
                last_q <= in_last;
                if (first_acc_c) thr_q <= thresh;
            end
            if (v_q) begin
                acc_q <= acc_new_c;
                if (close_c) begin
                    beat_q      <= '0;
                    out_count_q <= acc_new_c;
                    out_fire_q  <= fire_c;
                    out_ovf_q   <= ~last_q;
                    out_valid_q <= 1'b1;
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_fire  = out_fire_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Directed bench for popcount_stream_acc; ternary vector added when POPCOUNT_TERNARY_EN is defined.
module tb_popcount_stream_acc;

    localparam int unsigned WIDTH     = 18;
    localparam int unsigned MAX_BEATS = 8;
    localparam int unsigned OUT_W     = 8;
`ifdef POPCOUNT_TERNARY_EN
    localparam int unsigned RES_W     = OUT_W + 1;
`else
    localparam int unsigned RES_W     = OUT_W;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] input_a;
`ifdef POPCOUNT_TERNARY_EN
    logic [WIDTH-1:0] input_b;
`endif
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [RES_W-1:0] thresh;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_count;
    logic             out_fire;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;

    popcount_stream_acc #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .input_a   (input_a),
`ifdef POPCOUNT_TERNARY_EN
        .input_b   (input_b),
`endif
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_fire  (out_fire),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) for the accepting edge
    task automatic send_beat(input logic [WIDTH-1:0] data, input logic last,
                             input logic [RES_W-1:0] thr);
        logic ok;
        ok       = 1'b0;
        input_a  = data;
        in_last  = last;
        thresh   = thr;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [RES_W-1:0] cnt,
                                input logic fire, input logic ovf);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        check({tag, "_fire"},  32'(out_fire),  32'(fire));
        check({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    initial begin
        rst       = 1'b1;
        input_a   = '0;
`ifdef POPCOUNT_TERNARY_EN
        input_b   = '0;
`endif
        in_valid  = 1'b0;
        in_last   = 1'b0;
        thresh    = '0;
        out_ready = 1'b1;

        step();
        step();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_fire",  32'(out_fire),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single full beat, threshold equal to count
        send_beat(18'h3FFFF, 1'b1, RES_W'(18));
        check("t1_in_ready_low", 32'(in_ready),  32'd0);
        check("t1_no_valid_yet", 32'(out_valid), 32'd0);
        step();
        check_result("t1", RES_W'(144 / 8), 1'b1, 1'b0);
        step();
        check("t1_consumed",   32'(out_valid), 32'd0);
        check("t1_in_ready",   32'(in_ready),  32'd1);

        // Three beats 1+4+2; later thresh changes must be ignored
        send_beat(18'h00001, 1'b0, RES_W'(8));
        send_beat(18'h0000F, 1'b0, RES_W'(0));
        send_beat(18'h30000, 1'b1, RES_W'(0));
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check_result("t2", RES_W'(7), 1'b0, 1'b0);
        check("t2_in_ready_hold", 32'(in_ready), 32'd0);
        step();
        check("t2_consumed", 32'(out_valid), 32'd0);
        check("t2_in_ready", 32'(in_ready),  32'd1);

        // Eight beats without last force-close; 9th beat offered and held off
        out_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_beat(18'h3FFFF, 1'b0, RES_W'(0));
        check("t3_in_ready_low", 32'(in_ready), 32'd0);
        input_a  = 18'h00001;
        in_last  = 1'b1;
        thresh   = RES_W'(2);
        in_valid = 1'b1;
        step();
        check_result("t3", RES_W'(144), 1'b1, 1'b1);
        for (int h = 0; h < 5; h++) begin
            step();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_count", 32'(out_count), 32'd144);
            check("t4_hold_fire",  32'(out_fire),  32'd1);
            check("t4_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        step();
        check("t4_consumed", 32'(out_valid), 32'd0);
        check("t4_in_ready", 32'(in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t3_beat9_closing", 32'(in_ready), 32'd0);
        step();
        check_result("t3b", RES_W'(1), 1'b0, 1'b0);
        step();
        check("t3b_consumed", 32'(out_valid), 32'd0);

        // Reset mid-frame discards partial accumulation and clears outputs
        send_beat(18'h3FFFF, 1'b0, RES_W'(50));
        send_beat(18'h3FFFF, 1'b0, RES_W'(50));
        rst = 1'b1;
        #1;
        check("t5_rst_count",    32'(out_count), 32'd0);
        check("t5_rst_valid",    32'(out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready),  32'd0);
        step();
        rst = 1'b0;
        step();
        check("t5_in_ready", 32'(in_ready), 32'd1);
        send_beat(18'h00003, 1'b1, RES_W'(0));
        step();
        check_result("t5", RES_W'(2), 1'b1, 1'b0);
        step();

`ifdef POPCOUNT_TERNARY_EN
        // 4 positive minus 8 negative bits = -4 against threshold -3
        input_b = 18'h0FF0F;
        send_beat(18'h000FF, 1'b1, RES_W'(9'h1FD));
        input_b = '0;
        step();
        check_result("t6", RES_W'(9'h1FC), 1'b0, 1'b0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcount_stream_acc.md
Name: popcount_stream_acc

Overview:
- Sequential, parametrised successor to the fixed 18-input combinational popcount cores.
- Accepts a frame of 1..MAX_BEATS input vectors of WIDTH bits over a valid/ready stream and popcounts each beat exactly in a registered stage.
- Accumulates the per-beat counts across the frame and emits the frame total plus a threshold-compare "fire" bit (neuron activation).
- Sits between the sensor/feature interface and the activation logic of a time-multiplexed printed neuron.

Parameters:
- WIDTH, 18: bits per input beat.
- MAX_BEATS, 8: maximum beats per frame.
- CNT_W, $clog2(WIDTH+1): per-beat count width (derived; do not override).
- OUT_W, $clog2(WIDTH*MAX_BEATS+1): accumulator/result width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_a  input  WIDTH  beat data.
- in_valid  input  1  beat valid.
- in_last  input  1  final beat of frame; qualified by in_valid.
- in_ready  output  1  beat accepted on an edge where in_valid & in_ready.
- thresh  input  OUT_W  fire threshold; sampled on the first accepted beat of each frame.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed on an edge where out_valid & out_ready.
- out_count  output  OUT_W  frame total.
- out_fire  output  1  out_count >= sampled thresh.
- out_ovf  output  1  frame was force-closed at MAX_BEATS without in_last.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; in_ready 0 while rst is high; stage-1 valid, accumulator, beat counter and state cleared. A reset mid-frame discards the partial frame and any pending result. in_ready goes to 1 on the first edge after rst deasserts.
- Stage 1 (on accept): cnt_q <= exact popcount(input_a); last_q <= in_last; v_q <= 1. Otherwise v_q <= 0.
- Stage 2 (when v_q): acc <= (first_beat ? 0 : acc) + cnt_q; beat counter increments.
  - Frame closes if last_q = 1, or if the counter reaches MAX_BEATS.
  - On close: out_count <= new acc; out_fire <= (new acc >= thr_q); out_ovf <= ~last_q; out_valid <= 1; first_beat <= 1; beat counter <= 0.
- State machine:
  - ACC: accepting beats.
  - CLOSE: one cycle; v_q holds a closing beat.
  - HOLD: out_valid high, waiting for out_ready.
  - Transitions: ACC -> CLOSE when a closing beat is accepted. CLOSE -> HOLD unconditionally. HOLD -> ACC on the out_valid & out_ready edge.
  - in_ready = 1 only in ACC.
- Closing beat for out_ovf: the beat taking the counter to MAX_BEATS is also a closing beat; in_ready drops after it.
- Latency: last beat accepted at edge E; out_valid high after edge E+1. With out_ready = 1, the result is consumed at E+2 and in_ready is high after E+2. Minimum frame period is beats + 2 cycles.
- out_count, out_fire and out_ovf hold stable while out_valid & ~out_ready. out_valid clears on consume.
- Single-beat frame (in_last on first beat): legal; out_count = that beat's popcount.
- in_last while not in_valid: ignored.
- Arithmetic: unsigned, no saturation needed, since OUT_W covers WIDTH*MAX_BEATS.
- thresh: sampled into thr_q with the first beat; changes mid-frame are ignored. thresh = 0 gives out_fire = 1 for every frame.

Optional Feature:
- Macro: POPCOUNT_TERNARY_EN.
- When defined:
  - Adds port input_b (input, WIDTH) as the negative-weight mask.
  - Per-beat value = popcount(input_a & ~input_b) - popcount(input_b & ~input_a), signed CNT_W+1.
  - Accumulator, out_count and thresh become signed OUT_W+1; the compare is signed.
  - Bits set in both input_a and input_b contribute 0.
- When undefined: no input_b port; unsigned behaviour as above.

Test Plan:
- Reset, then a 1-beat frame with input_a = 18'h3FFFF, in_last = 1, thresh = 18, out_ready = 1 -> out_valid high after edge E+1; out_count = 18; out_fire = 1; out_ovf = 0.
- 3-beat frame 18'h00001, 18'h0000F, 18'h30000 (last), thresh = 8 -> out_count = 7; out_fire = 0; in_ready low from the edge after the last accept until the consume edge.
- 8 beats of 18'h3FFFF with in_last = 0 -> frame force-closes after beat 8; out_count = 144; out_ovf = 1; the 9th offered beat is held off (in_ready = 0) until the result is consumed.
- Result held with out_ready = 0 for 5 cycles -> out_count, out_fire and out_valid stable; no new beat accepted; consume on the 6th cycle -> in_ready = 1 next cycle.
- rst pulsed after 2 beats of a frame -> all outputs 0 immediately; the next frame of one beat 18'h00003 (last) gives out_count = 2, with no residue from the aborted frame.
- POPCOUNT_TERNARY_EN: input_a = 18'h000FF, input_b = 18'h0FF0F, thresh = -3 -> beat value 4 - 8 = -4; out_count = -4; out_fire = 0.
